// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display path: data geometry, arbiter
// state encoding and the 7-segment glyph table used by the display driver.
package hex_display_pkg;

  localparam int DIGITS = 4;
  localparam int DATA_W = 16;

  // Arbiter FSM states.
  typedef enum logic {
    IDLE = 1'b0,
    SHOW = 1'b1
  } arb_state_e;

  // 7-segment codes, bit order {g,f,e,d,c,b,a}, active-high segments.
  localparam logic [6:0] SEG_0 = 7'b0111111;
  localparam logic [6:0] SEG_1 = 7'b0000110;
  localparam logic [6:0] SEG_2 = 7'b1011011;
  localparam logic [6:0] SEG_3 = 7'b1001111;
  localparam logic [6:0] SEG_4 = 7'b1100110;
  localparam logic [6:0] SEG_5 = 7'b1101101;
  localparam logic [6:0] SEG_6 = 7'b1111101;
  localparam logic [6:0] SEG_7 = 7'b0000111;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1101111;
  localparam logic [6:0] SEG_A = 7'b1110111;
  localparam logic [6:0] SEG_B = 7'b1111100;
  localparam logic [6:0] SEG_C = 7'b0111001;
  localparam logic [6:0] SEG_D = 7'b1011110;
  localparam logic [6:0] SEG_E = 7'b1111001;
  localparam logic [6:0] SEG_F = 7'b1110001;

  // Map one hex nibble to its segment pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/hex_display_arbiter_rr_pick.sv
// Combinational round-robin picker: searches the request vector starting
// one position above the pointer, wrapping modulo NUM_REQ, and returns the
// first hit as a one-hot grant plus its index.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int               cand;
  logic [IDX_W-1:0] cand_idx;

  // Scan ptr+1 .. ptr+NUM_REQ (mod NUM_REQ); the first asserted request wins.
  always_comb begin
    grant    = '0;
    idx      = '0;
    any      = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand     = (int'(ptr) + off) % NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any && req[cand_idx]) begin
        any             = 1'b1;
        idx             = cand_idx;
        grant[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin arbiter sharing one 4-digit hex display between NUM_REQ
// requesters. An accepted value is latched onto o_data and held for
// HOLD_CYCLES cycles before the next arbitration.
// Optional build macro HEX_ARB_PRIO0_EN: requester 0 gets fixed priority
// and its grants leave the round-robin pointer untouched.
//
// Handshake: a transfer from requester k happens in a cycle where
// i_req_valid[k] and o_req_ready[k] are both 1. o_req_ready is one-hot,
// only ever set in IDLE (never while rst=1), and depends combinationally
// on i_req_valid; requesters may drop valid at any time before the grant.
module hex_display_arbiter
  import hex_display_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int HOLD_CYCLES = 50000000,
  parameter int IDX_W       = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        i_req_valid,
  input  logic [DATA_W*NUM_REQ-1:0] i_req_data,
  output logic [NUM_REQ-1:0]        o_req_ready,
  output logic [DATA_W-1:0]         o_data,
  output logic [IDX_W-1:0]          o_owner,
  output logic                      o_busy,
  output arb_state_e                dbg_state
);

  localparam int CNT_W = $clog2(HOLD_CYCLES + 1);

  arb_state_e          state;
  logic [IDX_W-1:0]    ptr;
  logic [CNT_W-1:0]    hold_cnt;

  logic [NUM_REQ-1:0]  pick_req;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [IDX_W-1:0]    pick_idx;
  logic                pick_any;

  logic [NUM_REQ-1:0]  win_grant;
  logic [IDX_W-1:0]    win_idx;
  logic                win_any;
  logic                accept;
  logic [DATA_W-1:0]   win_data;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

`ifdef HEX_ARB_PRIO0_EN
  // Requester 0 is removed from the rotation and overrides it when valid.
  assign pick_req = {i_req_valid[NUM_REQ-1:1], 1'b0};

  // Fixed-priority override for requester 0, else the round-robin winner.
  always_comb begin
    win_grant = pick_grant;
    win_idx   = pick_idx;
    win_any   = pick_any;
    if (i_req_valid[0]) begin
      win_grant    = '0;
      win_grant[0] = 1'b1;
      win_idx      = '0;
      win_any      = 1'b1;
    end
  end
`else
  assign pick_req  = i_req_valid;
  assign win_grant = pick_grant;
  assign win_idx   = pick_idx;
  assign win_any   = pick_any;
`endif

  // Grant is only offered in IDLE and never while reset is applied.
  assign o_req_ready = (state == IDLE && !rst) ? win_grant : '0;
  assign accept      = (state == IDLE) && win_any;
  assign dbg_state   = state;

  // Select the winning requester's data word.
  always_comb begin
    win_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx == IDX_W'(k)) begin
        win_data = i_req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  // Arbiter FSM: latch the winner in IDLE, then count down the hold time.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      o_data   <= '0;
      o_owner  <= '0;
      o_busy   <= 1'b0;
      hold_cnt <= '0;
      ptr      <= IDX_W'(NUM_REQ - 1);
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            o_data   <= win_data;
            o_owner  <= win_idx;
            o_busy   <= 1'b1;
            hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
            state    <= SHOW;
`ifdef HEX_ARB_PRIO0_EN
            // Priority grants to requester 0 do not disturb the rotation.
            if (win_idx != '0) begin
              ptr <= win_idx;
            end
`else
            ptr <= win_idx;
`endif
          end
        end
        SHOW: begin
          if (hold_cnt == '0) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Bench for hex_display_arbiter: directed steps in one initial block,
// accepted transfers checked against an expected queue.
module tb_hex_display_arbiter;
  import hex_display_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;
  localparam int HOLD    = 3;
  localparam int EW      = IDX_W + 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // main instance (HOLD_CYCLES=3)
  logic [NUM_REQ-1:0]    req_valid;
  logic [16*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]    req_ready;
  logic [15:0]           data;
  logic [IDX_W-1:0]      owner;
  logic                  busy;
  arb_state_e            state;

  // second instance (HOLD_CYCLES=1)
  logic [NUM_REQ-1:0]    valid_b;
  logic [16*NUM_REQ-1:0] data_b_in;
  logic [NUM_REQ-1:0]    ready_b;
  logic [15:0]           data_b;
  logic [IDX_W-1:0]      owner_b;
  logic                  busy_b;
  arb_state_e            state_b;

  hex_display_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(HOLD)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (req_valid),
    .i_req_data  (req_data),
    .o_req_ready (req_ready),
    .o_data      (data),
    .o_owner     (owner),
    .o_busy      (busy),
    .dbg_state   (state)
  );

  hex_display_arbiter #(.NUM_REQ(NUM_REQ), .HOLD_CYCLES(1)) dut_h1 (
    .clk         (clk),
    .rst         (rst),
    .i_req_valid (valid_b),
    .i_req_data  (data_b_in),
    .o_req_ready (ready_b),
    .o_data      (data_b),
    .o_owner     (owner_b),
    .o_busy      (busy_b),
    .dbg_state   (state_b)
  );

  // ---------------- scoreboard ----------------
  int n_cmp  = 0;
  int n_fail = 0;
  int cycle  = 0;
  logic [EW-1:0] exp_q[$];
  int accept_cyc[$];

  always @(posedge clk) cycle++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Inputs only change just after a rising edge, so a handshake seen at the
  // falling edge is the one the next rising edge will take.
  always @(negedge clk) begin
    if (rst === 1'b0 && |(req_valid & req_ready)) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $error("FAIL unexpected_accept: observed owner %0d data %h, expected no transfer", owner, data);
      end else begin
        check("accept", 32'({owner, data}), 32'(exp_q.pop_front()));
      end
      accept_cyc.push_back(cycle);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input string tag);
    int b;
    b = 0;
    while (busy !== 1'b0 && b < 50) begin
      tick(1);
      b++;
    end
    check(tag, 32'(busy), 32'(0));
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int base;
    int b;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    valid_b   = '0;
    data_b_in = '0;
    tick(2);

    // reset state
    check("rst_data",  32'(data),  32'(0));
    check("rst_owner", 32'(owner), 32'(0));
    check("rst_busy",  32'(busy),  32'(0));
    check("rst_state", 32'(state), 32'(IDLE));
    req_valid = '1;
    #1;
    check("rst_ready_masked", 32'(req_ready), 32'(0));
    req_valid = '0;
    rst = 1'b0;
    tick(1);

    // 1: single request from requester 2
    req_data[47:32] = 16'hBEEF;
    req_valid = 4'b0100;
    exp_q.push_back({2'd2, 16'hBEEF});
    #1;
    check("t1_ready", 32'(req_ready), 32'(4'b0100));
    tick(1);
    req_valid = '0;
    check("t1_data",  32'(data),  32'(16'hBEEF));
    check("t1_owner", 32'(owner), 32'(2));
    check("t1_busy0", 32'(busy),  32'(1));
    check("t1_state", 32'(state), 32'(SHOW));
    for (int i = 1; i < HOLD; i++) begin
      tick(1);
      check("t1_busy_hold", 32'(busy), 32'(1));
    end
    tick(1);
    check("t1_busy_end", 32'(busy),  32'(0));
    check("t1_data_kept", 32'(data), 32'(16'hBEEF));
    check("t1_idle", 32'(state), 32'(IDLE));

`ifndef HEX_ARB_PRIO0_EN
    // 2: everyone valid, fresh pointer -> 0,1,2,3,0 spaced HOLD+1 apart
    pulse_reset();
    for (int k = 0; k < NUM_REQ; k++) req_data[k*16 +: 16] = 16'(k);
    exp_q.push_back({2'd0, 16'h0000});
    exp_q.push_back({2'd1, 16'h0001});
    exp_q.push_back({2'd2, 16'h0002});
    exp_q.push_back({2'd3, 16'h0003});
    exp_q.push_back({2'd0, 16'h0000});
    base = accept_cyc.size();
    req_valid = '1;
    b = 0;
    while (accept_cyc.size() < base + 5 && b < 40) begin
      tick(1);
      b++;
    end
    req_valid = '0;
    check("t2_accept_count", 32'(accept_cyc.size() - base), 32'(5));
    for (int i = 1; i < 5; i++) begin
      if (accept_cyc.size() >= base + i + 1)
        check("t2_spacing", 32'(accept_cyc[base+i] - accept_cyc[base+i-1]), 32'(HOLD + 1));
    end
    wait_idle("t2_idle");
`endif

    // 3: a request that only lives during SHOW is never granted
    req_data[63:48] = 16'h3333;
    req_valid = 4'b1000;
    exp_q.push_back({2'd3, 16'h3333});
    tick(1);
    req_valid = 4'b0010;
    req_data[31:16] = 16'h1111;
    req_data[63:48] = 16'hFFFF;
    #1;
    check("t3_ready_show1", 32'(req_ready), 32'(0));
    tick(1);
    check("t3_ready_show2", 32'(req_ready), 32'(0));
    check("t3_data_frozen", 32'(data), 32'(16'h3333));
    tick(1);
    check("t3_ready_show3", 32'(req_ready), 32'(0));
    req_valid = '0;
    tick(1);
    check("t3_idle", 32'(state), 32'(IDLE));
    check("t3_ready_idle", 32'(req_ready), 32'(0));
    tick(2);
    check("t3_data_kept",  32'(data),  32'(16'h3333));
    check("t3_owner_kept", 32'(owner), 32'(3));

    // 4: reset in the second SHOW cycle
    req_data[15:0] = 16'hA0A0;
    req_valid = 4'b0001;
    exp_q.push_back({2'd0, 16'hA0A0});
    tick(1);
    req_valid = '0;
    tick(1);
    check("t4_busy_before_rst", 32'(busy), 32'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t4_busy",  32'(busy),  32'(0));
    check("t4_data",  32'(data),  32'(0));
    check("t4_owner", 32'(owner), 32'(0));
    check("t4_state", 32'(state), 32'(IDLE));
    // pointer is back at NUM_REQ-1, so requester 0 beats requester 3
    req_data[15:0]  = 16'h0101;
    req_data[63:48] = 16'h3C3C;
    req_valid = 4'b1001;
    exp_q.push_back({2'd0, 16'h0101});
    #1;
    check("t4_ready_0_vs_3", 32'(req_ready), 32'(4'b0001));
    tick(1);
    req_valid = '0;
    wait_idle("t4_idle_a");
    req_valid = 4'b1000;
    exp_q.push_back({2'd3, 16'h3C3C});
    #1;
    check("t4_ready_3_alone", 32'(req_ready), 32'(4'b1000));
    tick(1);
    req_valid = '0;
    check("t4_data_3", 32'(data), 32'(16'h3C3C));
    wait_idle("t4_idle_b");
    req_valid = 4'b1001;
    exp_q.push_back({2'd0, 16'h0101});
    #1;
    check("t4_ready_wrap", 32'(req_ready), 32'(4'b0001));
    tick(1);
    req_valid = '0;
    wait_idle("t4_idle_c");

    // 5: HOLD_CYCLES=1 instance, requester 1 always valid
    data_b_in[31:16] = 16'h5A5A;
    valid_b = 4'b0010;
    #1;
    check("t5_ready_first", 32'(ready_b), 32'(4'b0010));
    for (int i = 0; i < 4; i++) begin
      tick(1);
      check("t5_busy", 32'(busy_b), 32'((i % 2) == 0 ? 1 : 0));
      check("t5_ready", 32'(ready_b), 32'((i % 2) == 0 ? 4'b0000 : 4'b0010));
    end
    check("t5_data",  32'(data_b),  32'(16'h5A5A));
    check("t5_owner", 32'(owner_b), 32'(1));
    valid_b = '0;
    tick(2);

`ifdef HEX_ARB_PRIO0_EN
    // 6: requester 0 re-offers every other arbitration; others rotate
    begin
      int ord[6];
      ord = '{0, 1, 0, 2, 0, 3};
      pulse_reset();
      for (int k = 0; k < NUM_REQ; k++) req_data[k*16 +: 16] = 16'(16'h00A0 + k);
      for (int j = 0; j < 6; j++) begin
        req_valid = (j % 2 == 0) ? 4'b1111 : 4'b1110;
        exp_q.push_back({IDX_W'(ord[j]), 16'(16'h00A0 + ord[j])});
        #1;
        check("t6_ready", 32'(req_ready), 32'(1 << ord[j]));
        tick(1);
        req_valid = '0;
        tick(HOLD);
      end
    end
`endif

    tick(5);
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
